// File: rtl/dp_pkg.sv
`default_nettype none
// ============================================================================
// dp_pkg : shared types and parameter limits for dot_product_accumulator (rev 1.0)
// ============================================================================
package dp_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_LEN   = 4;
    localparam int DEF_ACC_W = 18;
    localparam int MIN_LEN   = 2;
    localparam int MAX_LEN   = 64;

    // Narrowest accumulator that can hold LEN full-scale 16-bit products.
    function automatic int min_acc_w(input int len);
        return 16 + $clog2(len);
    endfunction

    localparam int DEF_MIN_ACC_W = min_acc_w(DEF_LEN);

endpackage
`default_nettype wire

// File: rtl/multiplier_using_RCA.sv
`default_nettype none
// ============================================================================
// multiplier_using_RCA : unsigned 8x8 -> 16 array multiplier, ripple-carry rows (rev 1.0)
// ============================================================================
module multiplier_using_RCA (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] product
);

    logic [8:0] row [8];
    logic       carry;
    logic       x;
    logic       y;

    // Row i holds product bits i..i+8; each row ripples one shifted partial product in.
    always_comb begin
        product = '0;
        carry   = 1'b0;
        x       = 1'b0;
        y       = 1'b0;
        row[0]  = {1'b0, a & {8{b[0]}}};
        for (int i = 1; i < 8; i++) begin
            row[i] = '0;
        end
        product[0] = row[0][0];
        for (int i = 1; i < 8; i++) begin
            carry = 1'b0;
            for (int j = 0; j < 8; j++) begin
                x         = row[i-1][j+1];
                y         = a[j] & b[i];
                row[i][j] = x ^ y ^ carry;
                carry     = (x & y) | (carry & (x ^ y));
            end
            row[i][8]  = carry;
            product[i] = row[i][0];
        end
        product[15:8] = row[7][8:1];
    end

endmodule
`default_nettype wire

// File: rtl/dot_product_accumulator.sv
`default_nettype none
// ============================================================================
// dot_product_accumulator : streaming 8-bit dot product, LEN pairs per result (rev 1.0)
// ============================================================================
module dot_product_accumulator
    import dp_pkg::*;
#(
    parameter int LEN   = DEF_LEN,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             busy
);

    localparam int               CNT_W    = $clog2(LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

    if (LEN < MIN_LEN || LEN > MAX_LEN || ACC_W < min_acc_w(LEN)) begin : g_param_check
        $error("dot_product_accumulator: LEN must be 2..64 and ACC_W >= 16 + clog2(LEN)");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      p_q, p_d;
    logic             p_valid_q, p_valid_d;
    logic             p_last_q, p_last_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [15:0]      product;
    logic             accept;
    logic             take_result;
    logic             at_last;

    multiplier_using_RCA u_mult (
        .a       (a),
        .b       (b),
        .product (product)
    );

    // in_ready is a pure state decode so no combinational path reaches it from the inputs.
    assign in_ready    = (state_q == ACCUM);
    assign out_valid   = (state_q == DONE);
    assign out_sum     = acc_q;
    assign busy        = (cnt_q != '0) || p_valid_q || out_valid;
    assign accept      = in_valid && in_ready && !clear;
    assign take_result = out_valid && out_ready;
    assign at_last     = (cnt_q == LAST_CNT);

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ACCUM;
        end else begin
            case (state_q)
                ACCUM:   if (accept && at_last) state_d = DRAIN;
                // Stay while the final product is still being added into acc.
                DRAIN:   if (!(p_valid_q && p_last_q)) state_d = DONE;
                DONE:    if (out_ready) state_d = ACCUM;
                default: state_d = ACCUM;
            endcase
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        p_d       = p_q;
        p_valid_d = 1'b0;
        p_last_d  = p_last_q;
        acc_d     = acc_q;
        if (clear) begin
            cnt_d    = '0;
            p_last_d = 1'b0;
            acc_d    = '0;
        end else begin
            if (accept) begin
                p_d       = product;
                p_valid_d = 1'b1;
                p_last_d  = at_last;
                cnt_d     = at_last ? '0 : cnt_q + CNT_W'(1);
            end
            if (take_result) begin
                acc_d = '0;
                cnt_d = '0;
            end else if (p_valid_q) begin
                acc_d = acc_q + ACC_W'(p_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ACCUM;
            cnt_q     <= '0;
            p_q       <= '0;
            p_valid_q <= 1'b0;
            p_last_q  <= 1'b0;
            acc_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            p_q       <= p_d;
            p_valid_q <= p_valid_d;
            p_last_q  <= p_last_d;
            acc_q     <= acc_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dot_product_accumulator.sv
`default_nettype none
// ============================================================================
// tb_dot_product_accumulator : directed and random checks against a dot-product model (rev 1.0)
// ============================================================================
module tb_dot_product_accumulator;

    localparam int LEN   = 4;
    localparam int ACC_W = 18;

    typedef int vec_t [LEN];

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             clear     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b1;
    logic [7:0]       a         = 8'd0;
    logic [7:0]       b         = 8'd0;
    logic             in_ready;
    logic             out_valid;
    logic             busy;
    logic [ACC_W-1:0] out_sum;

    int n_cmp = 0;
    int n_err = 0;

    dot_product_accumulator #(
        .LEN   (LEN),
        .ACC_W (ACC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (observed=timeout required=finish)");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int dot(input vec_t pa, input vec_t pb);
        int s = 0;
        for (int i = 0; i < LEN; i++) s += pa[i] * pb[i];
        return s;
    endfunction

    task automatic feed(input vec_t pa, input vec_t pb, input int gap);
        for (int i = 0; i < LEN; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0;
                    step();
                end
            end
            in_valid = 1'b1;
            a = 8'(pa[i]);
            b = 8'(pb[i]);
            for (int w = 0; w < 40 && !in_ready; w++) step();
            check("feed_ready", 32'(in_ready), 1);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input int exp, input int bp);
        int lat = 0;
        out_ready = (bp == 0);
        check({tag, "_drain_rdy"}, 32'(in_ready), 0);
        check({tag, "_drain_ov"}, 32'(out_valid), 0);
        while (!out_valid && lat < 20) begin
            step();
            lat++;
            if (!out_valid) check({tag, "_wait_rdy"}, 32'(in_ready), 0);
        end
        check({tag, "_latency"}, 32'(lat), 2);
        check({tag, "_sum"}, 32'(out_sum), 32'(exp));
        check({tag, "_done_rdy"}, 32'(in_ready), 0);
        for (int c = 0; c < bp; c++) begin
            in_valid = 1'b1;
            a = 8'd7;
            b = 8'd7;
            step();
            check({tag, "_hold_ov"}, 32'(out_valid), 1);
            check({tag, "_hold_sum"}, 32'(out_sum), 32'(exp));
            check({tag, "_hold_rdy"}, 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        step();
        check({tag, "_post_ov"}, 32'(out_valid), 0);
        check({tag, "_post_rdy"}, 32'(in_ready), 1);
        check({tag, "_post_sum"}, 32'(out_sum), 0);
        check({tag, "_post_busy"}, 32'(busy), 0);
    endtask

    initial begin
        vec_t va, vb, ra, rb;
        logic saw;

        #1;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_sum", 32'(out_sum), 0);
        check("rst_busy", 32'(busy), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();

        va = '{10, 100, 120, 50};
        vb = '{10, 200, 100, 200};
        feed(va, vb, 0);
        collect("basic", 42100, 0);

        ra = '{255, 255, 255, 255};
        rb = '{255, 255, 255, 255};
        feed(ra, rb, 0);
        collect("max", 260100, 0);

        feed(va, vb, 0);
        collect("bp", 42100, 5);
        feed(va, vb, 0);
        collect("bp_next", dot(va, vb), 0);

        ra = '{40, 80, 1, 2};
        rb = '{60, 20, 1, 3};
        feed(ra, rb, 2);
        collect("bubbles", 4007, 0);

        in_valid = 1'b1;
        a = 8'd100;
        b = 8'd200;
        step();
        a = 8'd10;
        b = 8'd10;
        step();
        clear = 1'b1;
        a = 8'd5;
        b = 8'd5;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clear_busy", 32'(busy), 0);
        check("clear_sum", 32'(out_sum), 0);
        check("clear_rdy", 32'(in_ready), 1);
        ra = '{1, 1, 1, 1};
        rb = '{1, 1, 1, 1};
        feed(ra, rb, 0);
        collect("clear", 4, 0);

        feed(va, vb, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_out_sum", 32'(out_sum), 0);
        check("arst_in_ready", 32'(in_ready), 1);
        check("arst_busy", 32'(busy), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        saw = 1'b0;
        repeat (6) begin
            step();
            if (out_valid) saw = 1'b1;
        end
        check("arst_no_result", 32'(saw), 0);

        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < LEN; i++) begin
                ra[i] = int'($urandom_range(0, 255));
                rb[i] = int'($urandom_range(0, 255));
            end
            feed(ra, rb, int'($urandom_range(0, 2)));
            collect("rand", dot(ra, rb), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
